// File: rtl/angle_lut_pkg.sv
// Shared constants, state encoding and the index-to-angle table for angle_to_index.
// Table entries are round(acos(x) in degrees), x = i/63 (low half) or -(128-i)/63 (high half).
package angle_lut_pkg;

   localparam int NDATA        = 128;
   localparam int NDATA_LOG    = $clog2(NDATA);
   localparam int ANGLE_W      = 9;
   localparam int MAX_ANGLE    = 180;
   localparam int HALF_ANGLE   = 90;
   localparam int SEARCH_STEPS = 6;

   localparam logic [NDATA_LOG-1:0] LO_START = 7'd0;
   localparam logic [NDATA_LOG-1:0] LO_END   = 7'd63;
   localparam logic [NDATA_LOG-1:0] HI_START = 7'd65;
   localparam logic [NDATA_LOG-1:0] HI_END   = 7'd127;

   typedef enum logic [1:0] {IDLE, SEARCH, REFINE, DONE} state_t;

   // Index 64 sits between the two halves and is never reached by the search.
   localparam logic [ANGLE_W-1:0] ANGLE_TABLE [NDATA] = '{
      9'd90,  9'd89,  9'd88,  9'd87,  9'd86,  9'd85,  9'd85,  9'd84,
      9'd83,  9'd82,  9'd81,  9'd80,  9'd79,  9'd78,  9'd77,  9'd76,
      9'd75,  9'd74,  9'd73,  9'd72,  9'd71,  9'd71,  9'd70,  9'd69,
      9'd68,  9'd67,  9'd66,  9'd65,  9'd64,  9'd63,  9'd62,  9'd61,
      9'd59,  9'd58,  9'd57,  9'd56,  9'd55,  9'd54,  9'd53,  9'd52,
      9'd51,  9'd49,  9'd48,  9'd47,  9'd46,  9'd44,  9'd43,  9'd42,
      9'd40,  9'd39,  9'd37,  9'd36,  9'd34,  9'd33,  9'd31,  9'd29,
      9'd27,  9'd25,  9'd23,  9'd21,  9'd18,  9'd14,  9'd10,  9'd0,
      9'd0,   9'd180, 9'd170, 9'd166, 9'd162, 9'd159, 9'd157, 9'd155,
      9'd153, 9'd151, 9'd149, 9'd147, 9'd146, 9'd144, 9'd143, 9'd141,
      9'd140, 9'd138, 9'd137, 9'd136, 9'd134, 9'd133, 9'd132, 9'd131,
      9'd129, 9'd128, 9'd127, 9'd126, 9'd125, 9'd124, 9'd123, 9'd122,
      9'd121, 9'd119, 9'd118, 9'd117, 9'd116, 9'd115, 9'd114, 9'd113,
      9'd112, 9'd111, 9'd110, 9'd109, 9'd109, 9'd108, 9'd107, 9'd106,
      9'd105, 9'd104, 9'd103, 9'd102, 9'd101, 9'd100, 9'd99,  9'd98,
      9'd97,  9'd96,  9'd95,  9'd95,  9'd94,  9'd93,  9'd92,  9'd91
   };

endpackage

// File: rtl/angle_rom.sv
// Two-port combinational read of the shared index-to-angle table.
module angle_rom
   import angle_lut_pkg::*;
(
   input  logic [NDATA_LOG-1:0] addr_a,
   input  logic [NDATA_LOG-1:0] addr_b,
   output logic [ANGLE_W-1:0]   data_a,
   output logic [ANGLE_W-1:0]   data_b
);

   assign data_a = ANGLE_TABLE[addr_a];
   assign data_b = ANGLE_TABLE[addr_b];

endmodule

// File: rtl/angle_to_index.sv
// Angle (degrees) to nearest table index via 6-step binary search plus neighbour refinement.
// Build option ANGLE_CLAMP_EN: out-of-range angles are clamped to MAX_ANGLE instead of mapping to index 0.
//
// state  | meaning
// IDLE   | waiting for a request, in_ready high
// SEARCH | one binary-search step per cycle, step counter runs down to 0
// REFINE | pick c or c-1, whichever table angle is nearer (tie to lower)
// DONE   | present result one edge after entry, hold until out_ready
module angle_to_index
   import angle_lut_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ANGLE_W-1:0]   in_angle,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [NDATA_LOG-1:0] out_index,
   output logic                 out_err,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam logic [2:0] STEP_LOAD = 3'(SEARCH_STEPS - 1);

   state_t               state, state_nxt;
   logic [NDATA_LOG-1:0] lo, hi, lo_init, hi_init;
   logic [ANGLE_W-1:0]   angle, eff_angle;
   logic                 err, over;
   logic [2:0]           step;
   logic [NDATA_LOG:0]   mid_sum;
   logic [NDATA_LOG-1:0] mid, prev, addr_a, pick;
   logic [ANGLE_W-1:0]   data_a, data_b, d0, d1;
   logic                 at_start;

   angle_rom u_rom (
      .addr_a (addr_a),
      .addr_b (prev),
      .data_a (data_a),
      .data_b (data_b)
   );

   assign in_ready = (state == IDLE);

   always_comb begin
      over = in_angle > ANGLE_W'(MAX_ANGLE);
`ifdef ANGLE_CLAMP_EN
      eff_angle = over ? ANGLE_W'(MAX_ANGLE) : in_angle;
`else
      eff_angle = in_angle;
`endif
      lo_init = '0;
      hi_init = '0;
      if (eff_angle <= ANGLE_W'(HALF_ANGLE)) begin
         lo_init = LO_START;
         hi_init = LO_END;
      end else if (eff_angle <= ANGLE_W'(MAX_ANGLE)) begin
         lo_init = HI_START;
         hi_init = HI_END;
      end
   end

   // After the search lo holds c; its left neighbour is only meaningful off the range start.
   always_comb begin
      mid_sum  = {1'b0, lo} + {1'b0, hi};
      mid      = NDATA_LOG'(mid_sum >> 1);
      prev     = lo - NDATA_LOG'(1);
      addr_a   = (state == REFINE) ? lo : mid;
      d1       = angle - data_a;
      d0       = data_b - angle;
      at_start = (lo == LO_START) || (lo == HI_START);
      pick     = (at_start || (d0 > d1)) ? lo : prev;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (in_valid) state_nxt = SEARCH;
         SEARCH:  if (step == 3'd0) state_nxt = REFINE;
         REFINE:  state_nxt = DONE;
         DONE:    if (out_valid && out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lo        <= '0;
         hi        <= '0;
         angle     <= '0;
         err       <= 1'b0;
         step      <= '0;
         out_index <= '0;
         out_err   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (in_valid) begin
               angle <= eff_angle;
               err   <= over;
               lo    <= lo_init;
               hi    <= hi_init;
               step  <= STEP_LOAD;
            end
            SEARCH: begin
               step <= step - 3'd1;
               if (data_a <= angle) hi <= mid;
               else                 lo <= mid + NDATA_LOG'(1);
            end
            REFINE: begin
               out_index <= pick;
               out_err   <= err;
            end
            DONE: begin
               if (!out_valid)     out_valid <= 1'b1;
               else if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_angle_to_index.sv
// Randomised and directed bench for angle_to_index against an arccos-derived nearest-index model.
module tb_angle_to_index;

   localparam real PI = 3.14159265358979;

   logic       clk = 1'b0;
   logic       rst;
   logic [8:0] in_angle;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] out_index;
   logic       out_err;
   logic       out_valid;
   logic       out_ready;

   int n_checks = 0;
   int n_pass   = 0;
   int tbl [128];

   angle_to_index dut (
      .clk       (clk),
      .rst       (rst),
      .in_angle  (in_angle),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_index (out_index),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   function automatic int round_deg(input real rad);
      return $rtoi($floor(rad * 180.0 / PI + 0.5));
   endfunction

   task automatic build_table();
      for (int k = 0; k < 64; k++) tbl[k] = round_deg($acos(real'(k) / 63.0));
      tbl[64] = 0;
      for (int i = 65; i < 128; i++) tbl[i] = round_deg($acos(-real'(128 - i) / 63.0));
   endtask

   // Nearest table entry within the half that covers the angle; first (lowest) index wins ties.
   function automatic int model_index(input int a);
      int lo, hi, best, bestd, d;
      if (a > 180) begin
`ifdef ANGLE_CLAMP_EN
         a = 180;
`else
         return 0;
`endif
      end
      lo = (a <= 90) ? 0 : 65;
      hi = (a <= 90) ? 63 : 127;
      best = lo;
      bestd = 100000;
      for (int i = lo; i <= hi; i++) begin
         d = tbl[i] - a;
         if (d < 0) d = -d;
         if (d < bestd) begin
            bestd = d;
            best  = i;
         end
      end
      return best;
   endfunction

   task automatic run_req(input int a, output int idx, output int err, output int lat);
      @(negedge clk);
      in_angle  = 9'(a);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (out_valid !== 1'b1) lat = -1;
      idx = int'(out_index);
      err = int'(out_err);
   endtask

   task automatic drain();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_index !== 7'd0 || out_err !== 1'b0)
         $display("FAIL reset_state got ready=%b valid=%b idx=%0d err=%b exp 1 0 0 0",
                  in_ready, out_valid, out_index, out_err);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed(input int a, input int exp_idx, input string name);
      int idx, err, lat;
      run_req(a, idx, err, lat);
      n_checks++;
      if (idx !== exp_idx) $display("FAIL %s_idx angle=%0d got=%0d exp=%0d", name, a, idx, exp_idx);
      else n_pass++;
      n_checks++;
      if (idx !== model_index(a)) $display("FAIL %s_model angle=%0d got=%0d exp=%0d", name, a, idx, model_index(a));
      else n_pass++;
      n_checks++;
      if (err !== 0) $display("FAIL %s_err angle=%0d got=%0d exp=0", name, a, err);
      else n_pass++;
      n_checks++;
      if (lat !== 8) $display("FAIL %s_latency angle=%0d got=%0d exp=8", name, a, lat);
      else n_pass++;
      drain();
   endtask

   task automatic test_corners();
      test_directed(90, 0, "corner");
      test_directed(0, 63, "corner");
      test_directed(180, 65, "corner");
      test_directed(91, 127, "corner");
   endtask

   task automatic test_tie_dup();
      test_directed(60, 31, "tie");
      test_directed(85, 5, "dup");
      test_directed(100, 117, "mid_hi");
      test_directed(2, 63, "near_zero");
   endtask

   task automatic test_backpressure();
      int idx, err, lat;
      run_req(45, idx, err, lat);
      n_checks++;
      if (idx !== 44 || lat !== 8) $display("FAIL bp_first got idx=%0d lat=%0d exp idx=44 lat=8", idx, lat);
      else n_pass++;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_index !== 7'd44 || in_ready !== 1'b0)
            $display("FAIL bp_hold cycle=%0d got valid=%b idx=%0d ready=%b exp 1 44 0",
                     c, out_valid, out_index, in_ready);
         else n_pass++;
      end
      drain();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL bp_release got valid=%b ready=%b exp 0 1", out_valid, in_ready);
      else n_pass++;
   endtask

   task automatic test_error();
      int idx, err, lat, a, exp_idx;
`ifdef ANGLE_CLAMP_EN
      exp_idx = 65;
`else
      exp_idx = 0;
`endif
      for (int n = 0; n < 4; n++) begin
         a = (n == 0) ? 200 : int'($urandom_range(181, 511));
         run_req(a, idx, err, lat);
         n_checks++;
         if (idx !== exp_idx || err !== 1 || lat !== 8)
            $display("FAIL error_angle angle=%0d got idx=%0d err=%0d lat=%0d exp idx=%0d err=1 lat=8",
                     a, idx, err, lat, exp_idx);
         else n_pass++;
         drain();
      end
   endtask

   task automatic test_reset_mid_search();
      int idx, err, lat;
      @(negedge clk);
      in_angle = 9'd120;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL busy_ready got=%b exp=0", in_ready);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_index !== 7'd0)
         $display("FAIL reset_mid got valid=%b ready=%b idx=%0d exp 0 1 0", out_valid, in_ready, out_index);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      run_req(90, idx, err, lat);
      n_checks++;
      if (idx !== 0 || err !== 0 || lat !== 8)
         $display("FAIL after_reset got idx=%0d err=%0d lat=%0d exp 0 0 8", idx, err, lat);
      else n_pass++;
      drain();
   endtask

   task automatic test_sweep();
      int a, idx, err, cyc;
      bit got;
      for (int n = 0; n < 211; n++) begin
         a = (n <= 180) ? n : int'($urandom_range(0, 511));
         cyc = 0;
         while (in_ready !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
         end
         @(negedge clk);
         in_angle = 9'(a);
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         got = 1'b0;
         idx = -1;
         err = -1;
         cyc = 0;
         while (!got && cyc < 100) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid === 1'b1 && out_ready) begin
               idx = int'(out_index);
               err = int'(out_err);
               got = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
         end
         out_ready = 1'b0;
         n_checks++;
         if (idx !== model_index(a)) $display("FAIL sweep_idx angle=%0d got=%0d exp=%0d", a, idx, model_index(a));
         else n_pass++;
         n_checks++;
         if (err !== ((a > 180) ? 1 : 0)) $display("FAIL sweep_err angle=%0d got=%0d exp=%0d", a, err, (a > 180) ? 1 : 0);
         else n_pass++;
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_angle  = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      build_table();
      test_reset();
      test_corners();
      test_tie_dup();
      test_backpressure();
      test_error();
      test_reset_mid_search();
      test_sweep();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
